muxn_sync: RTL and testbench
============================

MUXN_SYNC -- requirements
Module: muxn_sync

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (≥1).
REQ-002 Parameter NCH, default 4, channel count (2..16); derived localparam SELW = max(1, clog2(NCH)).
REQ-003 Parameter BLANK, default 2, switchover guard cycles (1..15).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 A  in  NCH*WIDTH  channel data, channel k at bits [k*WIDTH +: WIDTH].
REQ-007 sel_req  in  SELW  requested channel index.
REQ-008 sel_vld  in  1  select request valid.
REQ-009 sel_rdy  out  1  block accepts a select request this cycle.
REQ-010 cur_sel  out  SELW  currently routed channel.
REQ-011 Y  out  WIDTH  registered selected data.
REQ-012 y_vld  out  1  Y carries data of cur_sel.
REQ-013 sel_err  out  1  sticky: out-of-range request seen.

Function
REQ-014 States: LOCK (routing), GUARD (switchover), RELOCK (one-cycle refill); encoding from shared package.
REQ-015 Request accepted only when sel_vld && sel_rdy; sel_rdy = 1 only in LOCK.
REQ-016 LOCK: Y <= A[cur_sel] every cycle, 1-cycle latency; y_vld = 1.
REQ-017 Accepted sel_req == cur_sel: no-op, stay LOCK, no y_vld gap.
REQ-018 Accepted sel_req ≥ NCH: ignored, sel_err set next cycle, stay LOCK.
REQ-019 Accepted valid new index: latch into pending register, load counter with BLANK, go GUARD next cycle.
REQ-020 GUARD: y_vld = 0, sel_rdy = 0, counter decrements each cycle; at counter == 1, cur_sel <= pending, go RELOCK.
REQ-021 RELOCK: Y <= A[new cur_sel], y_vld = 0; next cycle go LOCK with y_vld = 1 and Y valid.
REQ-022 Total y_vld low time per switch = BLANK+1 cycles exactly.
REQ-023 sel_vld/sel_req in GUARD or RELOCK are not accepted and not queued.
REQ-024 cur_sel changes only on the GUARD→RELOCK transition.
REQ-025 sel_err clears only on rst.

Reset
REQ-026 On rst assertion, asynchronously: state LOCK, cur_sel 0, pending 0, counter 0, Y 0, sel_err 0, y_vld 0.
REQ-027 First cycle after rst release: y_vld 0, Y <= A[0]; y_vld 1 from second cycle.
REQ-028 rst during GUARD/RELOCK aborts switchover; cur_sel returns to 0, pending discarded.

Configuration
REQ-029 Macro MUXN_SYNC_BLANK_EN defined: Y forced to 0 during GUARD and RELOCK.
REQ-030 Macro undefined: Y holds last LOCK value during GUARD; RELOCK behaviour per REQ-021.
REQ-031 y_vld, sel_rdy, cur_sel timing identical with or without the macro.

Structure
REQ-032 Package muxn_sync_pkg holds state enum, default WIDTH/NCH/BLANK constants, counter width constant (4).
REQ-033 Sub-module muxn_tree: purely combinational NCH:1 selector of WIDTH bits, balanced 2:1 tree, select bits preserved (synthesis keep) to force mux structure.
REQ-034 muxn_sync holds FSM, counter, pending/cur_sel, output and sel_err registers only.

Verification
REQ-035 Reset release, A ch0=0x11 -> cycle1 y_vld=0; cycle2 Y=0x11, y_vld=1, cur_sel=0.
REQ-036 LOCK, sel_req=2 one cycle, BLANK=2, ch2=0xA5 -> y_vld low 3 cycles, cur_sel=2 at GUARD end, then Y=0xA5, y_vld=1.
REQ-037 sel_req=cur_sel=1 -> no y_vld gap, sel_rdy stays 1, sel_err 0.
REQ-038 NCH=3, sel_req=3 -> ignored, cur_sel unchanged, sel_err=1 next cycle, held until rst.
REQ-039 sel_vld asserted every cycle during GUARD with other indices -> ignored, switch completes to first accepted index.
REQ-040 rst pulse mid-GUARD -> all outputs reset value immediately; both macro builds: Y=0 in GUARD with MUXN_SYNC_BLANK_EN, last value without.

Source files
------------

// File: rtl/muxn_sync_pkg.sv
// Shared definitions for the synchronous guarded N:1 multiplexer.
//   state_e     : FSM encoding (LOCK / GUARD / RELOCK)
//   DEF_*       : default WIDTH / NCH / BLANK parameter values
//   CNT_W       : width of the switchover guard counter
//   sel_width() : select width for a channel count, never below 1
package muxn_sync_pkg;

  typedef enum logic [1:0] {
    ST_LOCK   = 2'd0,
    ST_GUARD  = 2'd1,
    ST_RELOCK = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned DEF_BLANK = 2;
  localparam int unsigned CNT_W     = 4;

  // Select width for n channels: max(1, clog2(n)).
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 32'd2) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/muxn_tree.sv
// Purely combinational NCH:1 selector built as a balanced 2:1 mux tree.
//   a   : NCH*WIDTH channel data, channel k at a[k*WIDTH +: WIDTH]
//   sel : channel index (indices >= NCH select zero)
//   y   : selected channel data
module muxn_tree #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic [NCH*WIDTH-1:0] a,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     y
);

  localparam int unsigned NP = 32'(1) << SELW;

  // Select bits kept so synthesis builds the explicit tree instead of
  // collapsing it into a flattened and-or structure.
  (* keep = "true" *) logic [SELW-1:0] sel_keep;
  assign sel_keep = sel;

  // Heap-indexed tree: node 1 is the root, leaves sit at NP..2*NP-1.
  logic [WIDTH-1:0] node [1:2*NP-1];

  genvar k, lvl, j;

  // Leaves: real channels, padded with zero up to the power of two.
  for (k = 0; k < NP; k++) begin : g_leaf
    if (k < NCH) begin : g_ch
      assign node[NP+k] = a[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign node[NP+k] = '0;
    end
  end

  // Root level uses the select MSB, leaf-side level uses the LSB.
  for (lvl = 0; lvl < SELW; lvl++) begin : g_lvl
    for (j = 0; j < (1 << lvl); j++) begin : g_node
      localparam int unsigned I = (32'(1) << lvl) + j;
      assign node[I] = sel_keep[SELW-1-lvl] ? node[2*I+1] : node[2*I];
    end
  end

  assign y = node[1];

endmodule

// File: rtl/muxn_sync.sv
// Registered N:1 multiplexer with a guarded channel switchover.
// A select request is taken only in LOCK; a change of channel blanks y_vld
// for BLANK guard cycles plus one refill cycle before the new channel is
// presented. Out-of-range requests are dropped and flagged in sticky sel_err.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   A        : NCH*WIDTH channel data, channel k at A[k*WIDTH +: WIDTH]
//   sel_req  : requested channel, qualified by sel_vld
//   sel_rdy  : request accepted this cycle (high only in LOCK)
//   cur_sel  : currently routed channel
//   Y, y_vld : registered selected data and its valid flag
//   sel_err  : sticky out-of-range request flag
// Build option: define MUXN_SYNC_BLANK_EN to drive Y to zero during the
// switchover; otherwise Y holds the last LOCK value through GUARD.
module muxn_sync
  import muxn_sync_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned NCH   = DEF_NCH,
  parameter  int unsigned BLANK = DEF_BLANK,
  localparam int unsigned SELW  = sel_width(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] A,
  input  logic [SELW-1:0]      sel_req,
  input  logic                 sel_vld,
  output logic                 sel_rdy,
  output logic [SELW-1:0]      cur_sel,
  output logic [WIDTH-1:0]     Y,
  output logic                 y_vld,
  output logic                 sel_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SELW-1:0]  pend_q, pend_d;
  logic [SELW-1:0]  cur_sel_q, cur_sel_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_vld_q, y_vld_d;
  logic             sel_rdy_q, sel_rdy_d;
  logic             sel_err_q, sel_err_d;
  logic [WIDTH-1:0] a_sel;

  // Channel selector driven by the registered routing index.
  muxn_tree #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SELW  (SELW)
  ) u_tree (
    .a   (A),
    .sel (cur_sel_q),
    .y   (a_sel)
  );

  // Next-state, counter, select and output register logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    cur_sel_d = cur_sel_q;
    sel_err_d = sel_err_q;
    y_d       = y_q;

    case (state_q)
      ST_LOCK: begin
        if (sel_vld) begin
          if (32'(sel_req) >= NCH) begin
            sel_err_d = 1'b1;
          end else if (sel_req != cur_sel_q) begin
            pend_d  = sel_req;
            cnt_d   = CNT_W'(BLANK);
            state_d = ST_GUARD;
          end
        end
      end
      ST_GUARD: begin
        // Routing index moves only here, on the last guard cycle.
        if (cnt_q == CNT_W'(1)) begin
          cur_sel_d = pend_q;
          cnt_d     = '0;
          state_d   = ST_RELOCK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RELOCK: begin
        state_d = ST_LOCK;
      end
      default: begin
        state_d = ST_LOCK;
      end
    endcase

    // Y samples the routed channel in LOCK and RELOCK, holds through GUARD.
    if (state_q != ST_GUARD) begin
      y_d = a_sel;
    end
`ifdef MUXN_SYNC_BLANK_EN
    if (state_d != ST_LOCK) begin
      y_d = '0;
    end
`endif

    y_vld_d   = (state_d == ST_LOCK);
    sel_rdy_d = (state_d == ST_LOCK);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOCK;
      cnt_q     <= '0;
      pend_q    <= '0;
      cur_sel_q <= '0;
      y_q       <= '0;
      y_vld_q   <= 1'b0;
      sel_rdy_q <= 1'b1;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      cur_sel_q <= cur_sel_d;
      y_q       <= y_d;
      y_vld_q   <= y_vld_d;
      sel_rdy_q <= sel_rdy_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_rdy = sel_rdy_q;
  assign cur_sel = cur_sel_q;
  assign Y       = y_q;
  assign y_vld   = y_vld_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_muxn_sync.sv
// Directed bench for muxn_sync: a default instance (WIDTH 8, NCH 4, BLANK 2)
// and a three-channel instance (NCH 3, BLANK 1) for out-of-range requests.
module tb_muxn_sync;

`ifdef MUXN_SYNC_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [1:0]  sel_req;
  logic        sel_vld;
  logic        sel_rdy;
  logic [1:0]  cur_sel;
  logic [7:0]  y;
  logic        y_vld;
  logic        sel_err;

  logic [23:0] a2;
  logic [1:0]  sel_req2;
  logic        sel_vld2;
  logic        sel_rdy2;
  logic [1:0]  cur_sel2;
  logic [7:0]  y2;
  logic        y_vld2;
  logic        sel_err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muxn_sync #(.WIDTH(8), .NCH(4), .BLANK(2)) dut (
    .clk(clk), .rst(rst), .A(a), .sel_req(sel_req), .sel_vld(sel_vld),
    .sel_rdy(sel_rdy), .cur_sel(cur_sel), .Y(y), .y_vld(y_vld), .sel_err(sel_err)
  );

  muxn_sync #(.WIDTH(8), .NCH(3), .BLANK(1)) dut2 (
    .clk(clk), .rst(rst), .A(a2), .sel_req(sel_req2), .sel_vld(sel_vld2),
    .sel_rdy(sel_rdy2), .cur_sel(cur_sel2), .Y(y2), .y_vld(y_vld2), .sel_err(sel_err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel_vld = 1'b0; sel_req = 2'd0; sel_vld2 = 1'b0; sel_req2 = 2'd0;
    a = 32'h44A5_2211; a2 = 24'h33_2211;
    step(); step();
    total++; if (y_vld !== 1'b0) begin bad++; $display("FAIL rst_y_vld got=%b want=0", y_vld); end
    total++; if (y !== 8'h00) begin bad++; $display("FAIL rst_y got=%h want=00", y); end
    total++; if (cur_sel !== 2'd0) begin bad++; $display("FAIL rst_cur_sel got=%0d want=0", cur_sel); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL rst_sel_err got=%b want=0", sel_err); end
    rst = 1'b0;
    #2;
    total++; if (y_vld !== 1'b0) begin bad++; $display("FAIL rel_cycle1_y_vld got=%b want=0", y_vld); end
    step();
    total++; if (y !== 8'h11) begin bad++; $display("FAIL rel_cycle2_y got=%h want=11", y); end
    total++; if (y_vld !== 1'b1) begin bad++; $display("FAIL rel_cycle2_y_vld got=%b want=1", y_vld); end
    total++; if (cur_sel !== 2'd0) begin bad++; $display("FAIL rel_cycle2_cur_sel got=%0d want=0", cur_sel); end
    total++; if (sel_rdy !== 1'b1) begin bad++; $display("FAIL rel_cycle2_sel_rdy got=%b want=1", sel_rdy); end
    total++; if (y2 !== 8'h11 || y_vld2 !== 1'b1) begin bad++; $display("FAIL rel_dut2 got y=%h v=%b want y=11 v=1", y2, y_vld2); end
  endtask

  // One-cycle request from prev to idx with BLANK=2: y_vld low three cycles.
  task automatic do_switch(input logic [1:0] idx, input logic [1:0] prev,
                           input logic [7:0] old_y, input logic [7:0] new_y);
    logic [7:0] gy;
    gy = BLANK_EN ? 8'h00 : old_y;
    sel_req = idx; sel_vld = 1'b1;
    step();
    sel_vld = 1'b0; sel_req = prev;
    total++; if (y_vld !== 1'b0 || sel_rdy !== 1'b0) begin bad++; $display("FAIL sw_g1 got v=%b r=%b want v=0 r=0", y_vld, sel_rdy); end
    total++; if (cur_sel !== prev || y !== gy) begin bad++; $display("FAIL sw_g1_data got sel=%0d y=%h want sel=%0d y=%h", cur_sel, y, prev, gy); end
    step();
    total++; if (y_vld !== 1'b0 || cur_sel !== prev || y !== gy) begin bad++; $display("FAIL sw_g2 got v=%b sel=%0d y=%h want v=0 sel=%0d y=%h", y_vld, cur_sel, y, prev, gy); end
    step();
    total++; if (y_vld !== 1'b0 || cur_sel !== idx || y !== gy) begin bad++; $display("FAIL sw_relock got v=%b sel=%0d y=%h want v=0 sel=%0d y=%h", y_vld, cur_sel, y, idx, gy); end
    step();
    total++; if (y_vld !== 1'b1 || sel_rdy !== 1'b1) begin bad++; $display("FAIL sw_lock got v=%b r=%b want v=1 r=1", y_vld, sel_rdy); end
    total++; if (y !== new_y || cur_sel !== idx) begin bad++; $display("FAIL sw_lock_data got y=%h sel=%0d want y=%h sel=%0d", y, cur_sel, new_y, idx); end
  endtask

  task automatic test_same();
    sel_req = 2'd1; sel_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (y_vld !== 1'b1 || sel_rdy !== 1'b1 || sel_err !== 1'b0) begin bad++; $display("FAIL same_flags got v=%b r=%b e=%b want 1 1 0", y_vld, sel_rdy, sel_err); end
      total++; if (cur_sel !== 2'd1 || y !== 8'h22) begin bad++; $display("FAIL same_data got sel=%0d y=%h want sel=1 y=22", cur_sel, y); end
    end
    sel_vld = 1'b0;
    a[15:8] = 8'h5A;
    step();
    total++; if (y !== 8'h5A) begin bad++; $display("FAIL lock_latency got=%h want=5a", y); end
    a[15:8] = 8'h22;
    step();
    total++; if (y !== 8'h22) begin bad++; $display("FAIL lock_restore got=%h want=22", y); end
  endtask

  task automatic test_err();
    total++; if (sel_err2 !== 1'b0) begin bad++; $display("FAIL err_pre got=%b want=0", sel_err2); end
    sel_req2 = 2'd3; sel_vld2 = 1'b1;
    step();
    sel_vld2 = 1'b0; sel_req2 = 2'd0;
    total++; if (sel_err2 !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", sel_err2); end
    total++; if (cur_sel2 !== 2'd0 || y_vld2 !== 1'b1 || sel_rdy2 !== 1'b1) begin bad++; $display("FAIL err_ignored got sel=%0d v=%b r=%b want 0 1 1", cur_sel2, y_vld2, sel_rdy2); end
    // valid switch to ch2 with BLANK=1: two low cycles, error stays set
    sel_req2 = 2'd2; sel_vld2 = 1'b1;
    step();
    sel_vld2 = 1'b0;
    total++; if (y_vld2 !== 1'b0 || cur_sel2 !== 2'd0) begin bad++; $display("FAIL err_sw_g got v=%b sel=%0d want v=0 sel=0", y_vld2, cur_sel2); end
    step();
    total++; if (y_vld2 !== 1'b0 || cur_sel2 !== 2'd2) begin bad++; $display("FAIL err_sw_relock got v=%b sel=%0d want v=0 sel=2", y_vld2, cur_sel2); end
    step();
    total++; if (y_vld2 !== 1'b1 || y2 !== 8'h33) begin bad++; $display("FAIL err_sw_lock got v=%b y=%h want v=1 y=33", y_vld2, y2); end
    total++; if (sel_err2 !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", sel_err2); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL err_other_dut got=%b want=0", sel_err); end
  endtask

  // Requests held during the switchover must not be accepted or queued.
  task automatic test_ignore_guard();
    int low;
    low = 0;
    sel_req = 2'd3; sel_vld = 1'b1;
    step();
    for (int i = 0; i < 10 && y_vld !== 1'b1; i++) begin
      low++;
      sel_req = (i % 2 == 0) ? 2'd0 : 2'd2;
      step();
    end
    sel_vld = 1'b0;
    total++; if (low !== 3) begin bad++; $display("FAIL ign_low_cycles got=%0d want=3", low); end
    total++; if (cur_sel !== 2'd3 || y !== 8'h44) begin bad++; $display("FAIL ign_target got sel=%0d y=%h want sel=3 y=44", cur_sel, y); end
    step(); step();
    total++; if (cur_sel !== 2'd3 || y_vld !== 1'b1 || y !== 8'h44) begin bad++; $display("FAIL ign_no_queue got sel=%0d v=%b y=%h want 3 1 44", cur_sel, y_vld, y); end
  endtask

  task automatic test_rst_guard();
    logic [7:0] gy;
    gy = BLANK_EN ? 8'h00 : 8'h44;
    sel_req = 2'd2; sel_vld = 1'b1;
    step();
    sel_vld = 1'b0;
    total++; if (y_vld !== 1'b0 || y !== gy) begin bad++; $display("FAIL rg_guard got v=%b y=%h want v=0 y=%h", y_vld, y, gy); end
    #2 rst = 1'b1;
    #1;
    total++; if (y_vld !== 1'b0 || y !== 8'h00 || cur_sel !== 2'd0) begin bad++; $display("FAIL rg_async got v=%b y=%h sel=%0d want 0 00 0", y_vld, y, cur_sel); end
    total++; if (sel_err2 !== 1'b0 || sel_rdy !== 1'b1) begin bad++; $display("FAIL rg_err_rdy got e2=%b r=%b want 0 1", sel_err2, sel_rdy); end
    step();
    rst = 1'b0;
    step();
    total++; if (y_vld !== 1'b1 || y !== 8'h11 || cur_sel !== 2'd0) begin bad++; $display("FAIL rg_after got v=%b y=%h sel=%0d want 1 11 0", y_vld, y, cur_sel); end
    step(); step();
    total++; if (cur_sel !== 2'd0 || y_vld !== 1'b1) begin bad++; $display("FAIL rg_pending_dropped got sel=%0d v=%b want 0 1", cur_sel, y_vld); end
  endtask

  initial begin
    test_reset();
    do_switch(2'd2, 2'd0, 8'h11, 8'hA5);
    do_switch(2'd1, 2'd2, 8'hA5, 8'h22);
    test_same();
    test_err();
    test_ignore_guard();
    test_rst_guard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
